// File: rtl/pwm_speed_pkg.sv
// rtl/pwm_speed_pkg.sv - shared types and constants for the PWM speed driver
package pwm_speed_pkg;

  typedef enum logic [1:0] {OFF, UP, DOWN, ON} state_t;

  localparam int LVL_W      = 3;
  localparam int PWM_PERIOD = 100;

  localparam logic [LVL_W-1:0] LVL_OFF = 3'b000;
  localparam logic [LVL_W-1:0] LVL_30  = 3'b001;
  localparam logic [LVL_W-1:0] LVL_50  = 3'b010;
  localparam logic [LVL_W-1:0] LVL_100 = 3'b100;

  localparam logic [6:0] DUTY_OFF = 7'd0;
  localparam logic [6:0] DUTY_30  = 7'd30;
  localparam logic [6:0] DUTY_50  = 7'd50;
  localparam logic [6:0] DUTY_100 = 7'd100;

  typedef struct packed {
    logic       legal;
    logic [6:0] duty;
  } level_dec_t;

  // One-hot speed request; anything else (multiple bits) is illegal.
  function automatic level_dec_t decode_level(input logic [LVL_W-1:0] code);
    level_dec_t d;
    d.legal = 1'b1;
    d.duty  = DUTY_OFF;
    case (code)
      LVL_OFF: d.duty = DUTY_OFF;
      LVL_30:  d.duty = DUTY_30;
      LVL_50:  d.duty = DUTY_50;
      LVL_100: d.duty = DUTY_100;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/level_sync.sv
// rtl/level_sync.sv - two-flop synchronizer for the asynchronous speed request
module level_sync
  import pwm_speed_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] lvl_s
);

  logic [LVL_W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= '0;
      lvl_s <= '0;
    end else begin
      meta  <= level;
      lvl_s <= meta;
    end
  end

endmodule

// File: rtl/pwm_speed_driver.sv
// rtl/pwm_speed_driver.sv - slew-limited PWM motor drive from a 3-bit speed request
module pwm_speed_driver
  import pwm_speed_pkg::*;
#(
  parameter int STEP         = 5,
  parameter int RAMP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [LVL_W-1:0] level,
  output logic             pwm_out,
  output logic [6:0]       duty,
  output logic             busy,
  output logic             fault
);

  localparam int                RDIV_W    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [6:0]        CNT_LAST  = 7'(PWM_PERIOD - 1);
  localparam logic [RDIV_W-1:0] RDIV_LAST = RDIV_W'(RAMP_PERIODS - 1);
  localparam logic [7:0]        STEP8     = 8'(STEP);
  localparam logic [6:0]        STEP7     = 7'(STEP);

  logic [LVL_W-1:0]  lvl_s;
  level_dec_t        lvl_dec;
  logic [6:0]        target;
  logic [6:0]        cnt;
  logic [RDIV_W-1:0] rdiv;
  logic              period_end;
  logic              slew_step;
  logic [7:0]        duty_inc;
  logic              up_clip;
  logic              dn_clip;
  logic [6:0]        duty_next;
  state_t            state;
  state_t            state_next;

  level_sync u_level_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .level (level),
    .lvl_s (lvl_s)
  );

  assign lvl_dec = decode_level(lvl_s);

  // Target and fault track the request even while the drive is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= DUTY_OFF;
      fault  <= 1'b0;
    end else begin
      fault <= !lvl_dec.legal;
      if (lvl_dec.legal) begin
        target <= lvl_dec.duty;
      end
    end
  end

  assign period_end = ena && (cnt == CNT_LAST);
  assign slew_step  = period_end && (rdiv == RDIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      rdiv <= '0;
    end else if (ena) begin
      cnt <= period_end ? '0 : cnt + 7'd1;
      if (period_end) begin
        rdiv <= slew_step ? '0 : rdiv + 1'b1;
      end
    end
  end

  // 8-bit headroom so duty+STEP cannot wrap before clipping to target.
  assign duty_inc = {1'b0, duty} + STEP8;
  assign up_clip  = duty_inc >= {1'b0, target};
  assign dn_clip  = {1'b0, duty} <= ({1'b0, target} + STEP8);

  always_comb begin
    duty_next = duty;
    if (target > duty) begin
      duty_next = up_clip ? target : duty_inc[6:0];
    end else if (target < duty) begin
      duty_next = dn_clip ? target : duty - STEP7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= DUTY_OFF;
    end else if (slew_step) begin
      duty <= duty_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= ena && (cnt < duty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
    end else if (ena) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ON;
    if (duty < target) begin
      state_next = UP;
    end else if (duty > target) begin
      state_next = DOWN;
    end else if (duty == DUTY_OFF) begin
      state_next = OFF;
    end
  end

  always_comb begin
    busy = (state == UP) || (state == DOWN);
  end

endmodule

// File: tb/tb_pwm_speed_driver.sv
// tb/tb_pwm_speed_driver.sv - table, directed and randomized checks of pwm_speed_driver
module tb_pwm_speed_driver;

  localparam int STEP         = 5;
  localparam int RAMP_PERIODS = 4;
  localparam int STEP_CYCLES  = 100 * RAMP_PERIODS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] level;
  logic       pwm_out;
  logic [6:0] duty;
  logic       busy;
  logic       fault;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  pwm_speed_driver #(.STEP(STEP), .RAMP_PERIODS(RAMP_PERIODS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .level   (level),
    .pwm_out (pwm_out),
    .duty    (duty),
    .busy    (busy),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle count e; a slew step closes every STEP_CYCLES-th enabled cycle.
  logic [2:0] m_q1, m_q2;
  int         m_target, m_duty, m_e;
  logic       m_fault, m_pwm, m_busy;

  function automatic int dec_level(input logic [2:0] c);
    case (c)
      3'b000:  return 0;
      3'b001:  return 30;
      3'b010:  return 50;
      3'b100:  return 100;
      default: return -1;
    endcase
  endfunction

  function automatic int slew(input int d, input int t);
    if (t > d) return (d + STEP < t) ? d + STEP : t;
    if (t < d) return (d - STEP > t) ? d - STEP : t;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q1 <= '0; m_q2 <= '0; m_target <= 0; m_duty <= 0; m_e <= 0;
      m_fault <= 1'b0; m_pwm <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_q1 <= level;
      m_q2 <= m_q1;
      if (dec_level(m_q2) >= 0) begin
        m_target <= dec_level(m_q2);
        m_fault  <= 1'b0;
      end else begin
        m_fault <= 1'b1;
      end
      if (ena) begin
        m_pwm  <= (m_e % 100) < m_duty;
        m_busy <= (m_duty != m_target);
        if (m_e % STEP_CYCLES == STEP_CYCLES - 1) m_duty <= slew(m_duty, m_target);
        m_e <= m_e + 1;
      end else begin
        m_pwm <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mdl_duty", duty, m_duty);
      chk("mdl_pwm", pwm_out, m_pwm);
      chk("mdl_busy", busy, m_busy);
      chk("mdl_fault", fault, m_fault);
    end
  end

  task automatic wait_duty(input string name, input int val, input int budget, input int exp_steps);
    int steps = 0;
    int n = 0;
    logic [6:0] last;
    last = duty;
    while (duty !== 7'(val) && n < budget) begin
      @(negedge clk);
      n++;
      if (duty !== last) begin
        steps++;
        last = duty;
      end
    end
    chk({name, "_reached"}, duty, val);
    chk({name, "_steps"}, steps, exp_steps);
  endtask

  task automatic count_high(input string name, input int exp);
    int hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk(name, hi, exp);
  endtask

  typedef struct {
    logic [2:0] lvl;
    logic       exp_fault;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int hi;
    vecs[0] = '{3'b001, 1'b0, 1'b1};
    vecs[1] = '{3'b011, 1'b1, 1'b1};
    vecs[2] = '{3'b000, 1'b0, 1'b0};
    vecs[3] = '{3'b110, 1'b1, 1'b0};
    vecs[4] = '{3'b111, 1'b1, 1'b0};
    vecs[5] = '{3'b100, 1'b0, 1'b1};
    vecs[6] = '{3'b101, 1'b1, 1'b1};
    vecs[7] = '{3'b010, 1'b0, 1'b1};
    vecs[8] = '{3'b000, 1'b0, 1'b0};

    rst_n = 1'b0; ena = 1'b0; level = 3'b000;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_duty", duty, 0);
    chk("reset_pwm", pwm_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fault", fault, 0);

    // Decode and fault table; stays well inside the first ramp interval so duty remains 0.
    ena = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      level = vecs[i].lvl;
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_duty", i), duty, 0);
    end

    // Ramp 0 -> 30 from a clean reset: six steps, one every four periods.
    rst_n = 1'b0;
    @(negedge clk);
    level = 3'b001; rst_n = 1'b1;
    repeat (STEP_CYCLES * 6 - 1) @(posedge clk);
    @(negedge clk);
    chk("ramp30_before", duty, 25);
    chk("ramp30_busy_mid", busy, 1);
    @(negedge clk);
    chk("ramp30_reached", duty, 30);
    @(negedge clk);
    chk("ramp30_busy_done", busy, 0);
    count_high("ramp30_pwm_high", 30);

    level = 3'b100;
    repeat (10) @(negedge clk);
    chk("up100_busy", busy, 1);
    wait_duty("up100", 100, 15 * STEP_CYCLES, 14);
    @(negedge clk);
    chk("up100_busy_done", busy, 0);
    count_high("up100_pwm_high", 100);

    level = 3'b000;
    repeat (10) @(negedge clk);
    chk("down0_busy", busy, 1);
    wait_duty("down0", 0, 21 * STEP_CYCLES, 20);
    @(negedge clk);
    chk("down0_busy_done", busy, 0);
    count_high("down0_pwm_high", 0);

    // Illegal request at duty 50 holds target and duty.
    level = 3'b010;
    wait_duty("up50", 50, 11 * STEP_CYCLES, 10);
    level = 3'b011;
    repeat (2) @(negedge clk);
    chk("fault_rise_early", fault, 0);
    @(negedge clk);
    chk("fault_rise", fault, 1);
    repeat (900) @(negedge clk);
    chk("fault_hold_duty", duty, 50);
    chk("fault_hold_busy", busy, 0);
    level = 3'b010;
    repeat (2) @(negedge clk);
    chk("fault_fall_early", fault, 1);
    @(negedge clk);
    chk("fault_fall", fault, 0);

    // Asynchronous reset in the middle of a ramp, then restart from zero.
    rst_n = 1'b0;
    level = 3'b001;
    @(negedge clk);
    rst_n = 1'b1;
    wait_duty("up15", 15, 4 * STEP_CYCLES, 3);
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_pwm", pwm_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_duty", duty, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (STEP_CYCLES - 1) @(posedge clk);
    @(negedge clk);
    chk("restart_before", duty, 0);
    @(negedge clk);
    chk("restart_step", duty, 5);

    // Freeze for 250 cycles; the period position must resume where it stopped.
    repeat (150) @(negedge clk);
    ena = 1'b0;
    hi = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk("freeze_pwm_high", hi, 0);
    chk("freeze_duty", duty, 5);
    ena = 1'b1;
    repeat (249) @(negedge clk);
    chk("resume_before", duty, 5);
    @(negedge clk);
    chk("resume_step", duty, 10);

    // Random requests, enables and occasional asynchronous reset pulses against the model.
    for (int s = 0; s < 40; s++) begin
      level = 3'($urandom_range(0, 7));
      ena   = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 600)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
